// File: rtl/execute_sequencer_if.sv
// Wishbone classic slave bus used by execute_sequencer. The signal names carry the
// slave's point of view (_i into the slave, _o out of it).
interface execute_sequencer_if;
  // Handshake: a request is stb & cyc, held by the master until it sees ack.
  // The slave acks exactly one cycle after a request it accepts, never on two
  // consecutive cycles, and rdata (wbs_dat_o) is valid only while ack is high.
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/execute_sequencer.sv
// Queues {instruction, rs1, rs2} commands written over Wishbone and issues them one
// at a time to the execute unit, capturing its 33-bit result and raising an IRQ.
module execute_sequencer #(
  parameter int DEPTH    = 4,
  parameter int EXEC_LAT = 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  execute_sequencer_if.slave   wb,
  output logic [31:0]          exe_instruction,
  output logic [31:0]          exe_rs1,
  output logic [31:0]          exe_rs2,
  input  logic [32:0]          exe_out,
  output logic                 irq,
  output logic [1:0]           dbg_state_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [CW-1:0] CNT_ONE   = 1;
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [3:0]    LAT_LOAD  = 4'(EXEC_LAT);

  localparam logic [2:0] REG_RS1       = 3'd0;
  localparam logic [2:0] REG_RS2       = 3'd1;
  localparam logic [2:0] REG_INSN      = 3'd2;
  localparam logic [2:0] REG_STATUS    = 3'd3;
  localparam logic [2:0] REG_RESULT_LO = 3'd4;
  localparam logic [2:0] REG_RESULT_HI = 3'd5;
  localparam logic [2:0] REG_CTRL      = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1
  } state_t;

  // Bus-side registers
  logic        ack_q;
  logic [31:0] dat_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic        run_q;
  logic        irq_en_q;
  logic        ovf_q;
  logic        udf_q;
  logic        irq_q;

  // Command FIFO
  logic [95:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Sequencer
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [32:0] result_q;
  logic        res_valid_q;
  logic [31:0] exe_insn_q;
  logic [31:0] exe_rs1_q;
  logic [31:0] exe_rs2_q;

  // Decoded strobes
  logic        wb_take;
  logic        wb_wr;
  logic        wb_rd;
  logic [2:0]  reg_sel;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        push_drop;
  logic        pop;
  logic        capture;
  logic        hi_read;
  logic [31:0] status_w;
  logic [31:0] rd_dat_d;
  logic        unused_bits;

  assign unused_bits = ^{wb.wbs_sel_i, wb.wbs_adr_i[31:5], wb.wbs_adr_i[1:0]};

  always_comb begin
    wb_take    = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q;
    wb_wr      = wb_take & wb.wbs_we_i;
    wb_rd      = wb_take & ~wb.wbs_we_i;
    reg_sel    = wb.wbs_adr_i[4:2];
    fifo_full  = (count_q == CNT_FULL);
    fifo_empty = (count_q == '0);
    push       = wb_wr & (reg_sel == REG_INSN) & ~fifo_full;
    push_drop  = wb_wr & (reg_sel == REG_INSN) & fifo_full;
    // A result still waiting to be read blocks the next issue.
    pop        = (state_q == S_IDLE) & run_q & ~fifo_empty & ~res_valid_q;
    capture    = (state_q == S_EXEC) & (cnt_q == 4'd0);
    hi_read    = wb_rd & (reg_sel == REG_RESULT_HI);
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    status_w      = 32'd0;
    status_w[0]   = fifo_full;
    status_w[1]   = fifo_empty;
    status_w[2]   = res_valid_q;
    status_w[3]   = (state_q != S_IDLE);
    status_w[8:4] = 5'(count_q);
    status_w[16]  = ovf_q;
    status_w[17]  = udf_q;
  end

  always_comb begin
    rd_dat_d = 32'd0;
    case (reg_sel)
      REG_RS1:       rd_dat_d = rs1_q;
      REG_RS2:       rd_dat_d = rs2_q;
      REG_STATUS:    rd_dat_d = status_w;
      REG_RESULT_LO: rd_dat_d = result_q[31:0];
      REG_RESULT_HI: rd_dat_d = {31'd0, result_q[32] & res_valid_q};
      REG_CTRL:      rd_dat_d = {30'd0, irq_en_q, run_q};
      default:       rd_dat_d = 32'd0;
    endcase
  end

  // Bus interface and software-visible registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
      rs1_q    <= 32'd0;
      rs2_q    <= 32'd0;
      run_q    <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ack_q <= wb_take;
      dat_q <= wb_rd ? rd_dat_d : 32'd0;
      irq_q <= res_valid_q & irq_en_q;
      if (wb_wr) begin
        case (reg_sel)
          REG_RS1: rs1_q <= wb.wbs_dat_i;
          REG_RS2: rs2_q <= wb.wbs_dat_i;
          REG_STATUS: begin
            if (wb.wbs_dat_i[16]) ovf_q <= 1'b0;
            if (wb.wbs_dat_i[17]) udf_q <= 1'b0;
          end
          REG_CTRL: begin
            run_q    <= wb.wbs_dat_i[0];
            irq_en_q <= wb.wbs_dat_i[1];
          end
          default: ;
        endcase
      end
      if (push_drop) ovf_q <= 1'b1;
      if (hi_read && !res_valid_q) udf_q <= 1'b1;
    end
  end

  // Command FIFO storage and pointers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 96'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {wb.wbs_dat_i, rs1_q, rs2_q};
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  // Issue FSM; exe_* registers hold the last issued command until the next pop.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      result_q    <= 33'd0;
      res_valid_q <= 1'b0;
      exe_insn_q  <= 32'd0;
      exe_rs1_q   <= 32'd0;
      exe_rs2_q   <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            {exe_insn_q, exe_rs1_q, exe_rs2_q} <= mem_q[rd_ptr_q];
            cnt_q   <= LAT_LOAD;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (capture) begin
            result_q    <= exe_out;
            res_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (hi_read && res_valid_q) res_valid_q <= 1'b0;
    end
  end

  assign wb.wbs_ack_o    = ack_q;
  assign wb.wbs_dat_o    = dat_q;
  assign exe_instruction = exe_insn_q;
  assign exe_rs1         = exe_rs1_q;
  assign exe_rs2         = exe_rs2_q;
  assign irq             = irq_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_execute_sequencer.sv
// Randomized bench for execute_sequencer: commands go through the Wishbone port and
// every result is compared with a queue of values computed from the written operands.
module tb_execute_sequencer;

  localparam int DEPTH    = 4;
  localparam int EXEC_LAT = 1;

  localparam logic [2:0] A_RS1 = 3'd0, A_RS2 = 3'd1, A_INSN = 3'd2, A_STATUS = 3'd3;
  localparam logic [2:0] A_LO  = 3'd4, A_HI  = 3'd5, A_CTRL = 3'd6;

  logic        clk;
  logic        rst_n;
  logic [31:0] exe_instruction;
  logic [31:0] exe_rs1;
  logic [31:0] exe_rs2;
  logic [32:0] exe_out;
  logic        irq;
  logic [1:0]  dbg_state;

  execute_sequencer_if wb_bus ();

  execute_sequencer #(.DEPTH(DEPTH), .EXEC_LAT(EXEC_LAT)) dut (
    .wb_clk_i        (clk),
    .wb_rst_ni       (rst_n),
    .wb              (wb_bus),
    .exe_instruction (exe_instruction),
    .exe_rs1         (exe_rs1),
    .exe_rs2         (exe_rs2),
    .exe_out         (exe_out),
    .irq             (irq),
    .dbg_state_o     (dbg_state)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] exp_q[$];
  bit          m_ovf;
  bit          m_udf;

  // Stand-in execute unit: a fixed function of the presented operands.
  function automatic logic [32:0] exe_fn(input logic [31:0] insn, input logic [31:0] a,
                                         input logic [31:0] b);
    return ({1'b0, a} + {1'b0, b}) ^ {1'b0, insn};
  endfunction

  assign exe_out = exe_fn(exe_instruction, exe_rs1, exe_rs2);

  function automatic logic [31:0] status_word(input bit full, input bit empty, input bit rv,
                                              input bit busy, input int count,
                                              input bit ovf, input bit udf);
    logic [31:0] s;
    s       = 32'd0;
    s[0]    = full;
    s[1]    = empty;
    s[2]    = rv;
    s[3]    = busy;
    s[8:4]  = 5'(count);
    s[16]   = ovf;
    s[17]   = udf;
    return s;
  endfunction

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic wb_xfer(input bit we, input logic [2:0] idx, input logic [31:0] wdata,
                         output logic [31:0] rdata);
    int n;
    @(negedge clk);
    wb_bus.wbs_stb_i = 1'b1;
    wb_bus.wbs_cyc_i = 1'b1;
    wb_bus.wbs_we_i  = we;
    wb_bus.wbs_sel_i = 4'hf;
    wb_bus.wbs_adr_i = {27'd0, idx, 2'b00};
    wb_bus.wbs_dat_i = wdata;
    n     = 0;
    rdata = 32'd0;
    while (n < 20) begin
      step();
      n++;
      if (wb_bus.wbs_ack_o) break;
    end
    if (!wb_bus.wbs_ack_o) check("wb_ack_timeout", 64'd0, 64'd1);
    rdata = wb_bus.wbs_dat_o;
    wb_bus.wbs_stb_i = 1'b0;
    wb_bus.wbs_cyc_i = 1'b0;
    wb_bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] idx, input logic [31:0] wdata);
    logic [31:0] dummy;
    wb_xfer(1'b1, idx, wdata, dummy);
  endtask

  task automatic wb_read(input logic [2:0] idx, output logic [31:0] rdata);
    wb_xfer(1'b0, idx, 32'd0, rdata);
  endtask

  task automatic push_cmd(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                          input bit dropped);
    wb_write(A_RS1, a);
    wb_write(A_RS2, b);
    wb_write(A_INSN, insn);
    if (dropped) m_ovf = 1'b1;
    else exp_q.push_back(exe_fn(insn, a, b));
  endtask

  task automatic wait_irq();
    int n;
    n = 0;
    while (!irq && n < 100) begin
      step();
      n++;
    end
    if (!irq) check("irq_timeout", 64'd0, 64'd1);
  endtask

  task automatic read_result(input string tag);
    logic [31:0] lo;
    logic [31:0] hi;
    logic [32:0] e;
    e = exp_q.pop_front();
    wb_read(A_LO, lo);
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
    wb_read(A_HI, hi);
    check({tag, "_hi"}, {32'd0, hi}, {63'd0, e[32]});
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      wait_irq();
      read_result(tag);
      step();
    end
  endtask

  logic [31:0] rd;
  logic [31:0] c_insn[3];
  logic [31:0] c_a[3];
  logic [31:0] c_b[3];

  initial begin
    rst_n            = 1'b0;
    wb_bus.wbs_stb_i = 1'b0;
    wb_bus.wbs_cyc_i = 1'b0;
    wb_bus.wbs_we_i  = 1'b0;
    wb_bus.wbs_sel_i = 4'h0;
    wb_bus.wbs_adr_i = 32'd0;
    wb_bus.wbs_dat_i = 32'd0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    step();
    check("rst_ack", {63'd0, wb_bus.wbs_ack_o}, 64'd0);
    check("rst_dat", {32'd0, wb_bus.wbs_dat_o}, 64'd0);
    check("rst_exe", {exe_instruction, exe_rs1 | exe_rs2}, 64'd0);
    check("rst_irq", {63'd0, irq}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    wb_read(A_STATUS, rd);
    check("rst_status", {32'd0, rd}, 64'h2);

    // Single command with fixed operands and issue timing
    wb_write(A_RS1, 32'd5);
    wb_write(A_RS2, 32'd7);
    wb_write(A_INSN, 32'h33);
    exp_q.push_back(exe_fn(32'h33, 32'd5, 32'd7));
    wb_write(A_CTRL, 32'd3);
    step();
    check("issue_rs1", {32'd0, exe_rs1}, 64'd5);
    check("issue_rs2", {32'd0, exe_rs2}, 64'd7);
    check("issue_insn", {32'd0, exe_instruction}, 64'h33);
    check("issue_busy", {63'd0, dbg_state != 2'd0}, 64'd1);
    step();
    step();
    check("irq_not_yet", {63'd0, irq}, 64'd0);
    step();
    check("irq_rise", {63'd0, irq}, 64'd1);
    read_result("basic");
    step();
    check("irq_fall", {63'd0, irq}, 64'd0);

    // Overflow with run off, then in-order drain and underflow
    wb_write(A_CTRL, 32'd2);
    for (int i = 0; i < 5; i++)
      push_cmd($urandom, $urandom, $urandom, i >= DEPTH);
    wb_read(A_STATUS, rd);
    check("full_status", {32'd0, rd}, {32'd0, status_word(1, 0, 0, 0, DEPTH, m_ovf, m_udf)});
    wb_write(A_CTRL, 32'd3);
    drain("fifo_order");
    wb_read(A_STATUS, rd);
    check("drained_status", {32'd0, rd}, {32'd0, status_word(0, 1, 0, 0, 0, m_ovf, m_udf)});
    wb_read(A_HI, rd);
    m_udf = 1'b1;
    check("underflow_data", {32'd0, rd}, 64'd0);
    wb_read(A_STATUS, rd);
    check("sticky_status", {32'd0, rd}, {32'd0, status_word(0, 1, 0, 0, 0, m_ovf, m_udf)});
    wb_write(A_STATUS, 32'h30000);
    m_ovf = 1'b0;
    m_udf = 1'b0;
    wb_read(A_STATUS, rd);
    check("sticky_clear", {32'd0, rd}, 64'h2);

    // Unread result blocks the next issue
    wb_write(A_CTRL, 32'd2);
    for (int i = 0; i < 3; i++) begin
      c_insn[i] = $urandom;
      c_a[i]    = $urandom;
      c_b[i]    = $urandom;
      push_cmd(c_insn[i], c_a[i], c_b[i], 1'b0);
    end
    wb_write(A_CTRL, 32'd3);
    wait_irq();
    repeat (5) step();
    check("hold_rs1", {32'd0, exe_rs1}, {32'd0, c_a[0]});
    check("hold_insn", {32'd0, exe_instruction}, {32'd0, c_insn[0]});
    wb_read(A_STATUS, rd);
    check("hold_status", {32'd0, rd}, {32'd0, status_word(0, 0, 1, 0, 2, 0, 0)});
    read_result("hold");
    step();
    check("next_rs1", {32'd0, exe_rs1}, {32'd0, c_a[1]});
    check("next_rs2", {32'd0, exe_rs2}, {32'd0, c_b[1]});
    drain("hold_rest");

    // Random rounds with run on, plus RS register read-back
    for (int r = 0; r < 6; r++) begin
      int k;
      logic [31:0] v;
      k = $urandom_range(1, DEPTH);
      for (int i = 0; i < k; i++) push_cmd($urandom, $urandom, $urandom, 1'b0);
      v = $urandom;
      wb_write(A_RS2, v);
      wb_read(A_RS2, rd);
      check("rs2_readback", {32'd0, rd}, {32'd0, v});
      drain("rand");
    end

    // Reset while a command is executing
    push_cmd($urandom, $urandom, $urandom, 1'b0);
    step();
    check("pre_rst_busy", {63'd0, dbg_state != 2'd0}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_exe", {exe_instruction, exe_rs1 | exe_rs2}, 64'd0);
    check("async_rst_state", {62'd0, dbg_state}, 64'd0);
    check("async_rst_irq", {63'd0, irq}, 64'd0);
    exp_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wb_read(A_STATUS, rd);
    check("post_rst_status", {32'd0, rd}, 64'h2);
    wb_read(A_CTRL, rd);
    check("post_rst_ctrl", {32'd0, rd}, 64'd0);
    push_cmd($urandom, $urandom, $urandom, 1'b0);
    wb_write(A_CTRL, 32'd3);
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/execute_sequencer.md
Name: execute_sequencer

Overview:
Wishbone-slave controller that queues {instruction, rs1, rs2} commands from the management SoC and issues them one at a time to the clocked execute unit (`__masc__execute`). It holds the operands stable for a fixed latency, captures the 33-bit result and raises an IRQ when the result is ready. Issue back-pressures on an unread result. It replaces logic-analyzer driving of the execute unit inside the user project wrapper.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, 2..16
EXEC_LAT, 1, cycles from operands driven to execute-unit result valid; 0..15

Ports:
wb_clk_i  in  1  system clock; all state on rising edge
wb_rst_ni  in  1  asynchronous, active-low reset
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects; ignored, all accesses are full-word
wbs_adr_i  in  32  address; only adr[4:2] decoded
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  ack
wbs_dat_o  out  32  read data
exe_instruction  out  32  instruction to execute unit
exe_rs1  out  32  operand 1
exe_rs2  out  32  operand 2
exe_out  in  33  execute-unit result
irq  out  1  result-ready interrupt

Behaviour:
- Reset: all registers 0, FSM in IDLE, FIFO empty; wbs_ack_o=0, wbs_dat_o=0, exe_*=0, irq=0.
- Wishbone timing:
  - Request = stb & cyc. Ack is registered and asserted for exactly one cycle, the cycle after a request while ack=0 (no back-to-back acks).
  - Register writes and side effects take effect on the acking edge. wbs_dat_o is valid with ack and 0 otherwise.
- Register map (adr[4:2]):
  - 0 RS1 (R/W).
  - 1 RS2 (R/W).
  - 2 INSN: write pushes {wdata, RS1, RS2} into the FIFO; read returns 0.
  - 3 STATUS (R): [0] full, [1] empty, [2] res_valid, [3] busy (FSM≠IDLE), [8:4] count, [16] overflow, [17] underflow. Writing 1 to bit 16 or 17 clears that bit.
  - 4 RESULT_LO (R): result[31:0], no side effect.
  - 5 RESULT_HI (R): {31'b0, result[32]}; if res_valid, clears res_valid (pop).
  - 6 CTRL (R/W): [0] run, [1] irq_en.
  - 7: reads 0, writes ignored.
- INSN write while full: entry dropped, overflow set.
- RESULT_HI read while res_valid=0: returns 0, underflow set.
- FSM:
  - IDLE → EXEC when run & !empty & !res_valid. On that edge: pop FIFO head into the exe_instruction/exe_rs1/exe_rs2 registers; load cnt=EXEC_LAT.
  - EXEC: if cnt≠0, cnt--. If cnt==0, capture exe_out into result, set res_valid, go to IDLE.
  - Result capture edge = pop edge + 1 + EXEC_LAT.
  - exe_* hold their values after completion until the next pop.
- Clearing run during EXEC does not abort; the current command completes and no further commands issue.
- Simultaneous push and pop in one cycle: both occur, count unchanged. A push to a full FIFO is dropped even if a pop occurs the same cycle.
- Simultaneous capture and RESULT_HI read cannot occur: capture requires res_valid=0.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- irq = res_valid & irq_en, registered (one cycle after res_valid rises or irq_en is set).
- Reset asserted mid-operation clears everything immediately, including in-flight commands and the result.

Test Plan:
- Reset → all outputs 0; STATUS reads 0x00000002 (empty only).
- EXEC_LAT=1: write RS1=5, RS2=7, INSN=0x00000033, CTRL=3 → exe_rs1=5 and exe_rs2=7 one cycle after pop; res_valid rises 2 cycles after pop; irq=1. Read RESULT_LO returns exe_out[31:0]. Read RESULT_HI returns exe_out[32]; irq falls.
- DEPTH=4, run=0: 5 INSN writes → count=4, full=1, overflow=1. Set run=1 and drain with RESULT_HI reads after each result → 4 results in FIFO order, then empty=1, busy=0.
- Leave a result unread with 2 commands queued → no second pop (exe_* unchanged, busy=0). Read RESULT_HI → next pop on the following cycle.
- RESULT_HI read with res_valid=0 → data 0, underflow=1. Write STATUS=0x30000 → both sticky bits cleared.
- Deassert wb_rst_ni during EXEC → FIFO empty, res_valid=0, exe_*=0 asynchronously. After release, the block is idle and accepts new commands.
